if_stage: RTL
=============

Name: if_stage

Overview:
- Fetch stage plus IF/ID pipeline register of the 5-stage MIPS core.
- Owns the PC and drives a variable-latency instruction-memory request/ready port.
- Applies branch/jump redirects coming from decode and squashes the wrong-path instruction.
- Delivers instrD, pcplus4D, opD and functD to decode and the controller. No branch delay slot.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- stallF  in  1  hazard unit: hold PC / do not advance fetch.
- stallD  in  1  hazard unit: hold the IF/ID register.
- pcsrcD  in  1  taken branch in decode.
- jumpD  in  1  jump in decode.
- pcbranchD  in  32  branch target computed in decode.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (= pcF).
- imem_ready  in  1  rdata valid this cycle; completes the request.
- imem_rdata  in  32  instruction word.
- instrD  out  32  IF/ID instruction.
- pcplus4D  out  32  IF/ID PC+4.
- validD  out  1  instrD is a real instruction, not a bubble.
- opD  out  6  instrD[31:26].
- functD  out  6  instrD[5:0].
- fetch_busy  out  1  imem_req & ~imem_ready (status only).

Behaviour:
- Reset (rst=1 at edge):
  - pcF=RESET_PC, state=FETCH.
  - instrD=0, pcplus4D=0, validD=0.
  - Holding buffer cleared; redirect register cleared.
  - Reset wins over every other input, including mid-request; any pending imem response is ignored.
- Redirect:
  - redir = (pcsrcD|jumpD) & ~stallD.
  - Target: jumpD ? {pcplus4D[31:28], instrD[25:0], 2'b00} : pcbranchD. Jump has priority over branch.
- Memory protocol:
  - imem_req=1 in FETCH and DROP; 0 in HOLD.
  - imem_addr = pcF; must remain stable while imem_req=1 and imem_ready=0.
  - Transfer happens when imem_req & imem_ready. A zero-wait memory (ready same cycle) gives 1 instruction/cycle.
- FETCH state:
  - redir=1: discard any returned word. pcF<=target if ready=1, otherwise latch target in the redirect register and go to DROP.
  - ready=1, stallF=0: deliver word, pcF<=pcF+4.
  - ready=1, stallF=1: store word and pcF+4 in the holding buffer; go to HOLD.
  - ready=0: no change to pcF.
- HOLD state:
  - redir=1: drop the buffer, pcF<=target, go to FETCH.
  - stallF=0: deliver the buffer, pcF<=pcF+4, go to FETCH.
  - Otherwise stay in HOLD.
- DROP state:
  - Keep the request active; on ready=1, discard the word, pcF<=redirect register, go to FETCH.
  - A further redir while in DROP overwrites the redirect register.
- IF/ID update (evaluated every cycle, in priority order):
  - rst: clear.
  - stallD=1: hold.
  - redir=1: load bubble (instrD=0, validD=0, pcplus4D=0).
  - Word delivered: instrD=word, pcplus4D=fetch PC+4, validD=1.
  - Otherwise: bubble.
- Timing/width rules:
  - No combinational path from stallF, stallD, pcsrcD or jumpD to imem_req or imem_addr.
  - opD and functD are pure slices of instrD.
  - PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
  - The PC never updates without a delivered or dropped transfer, except on redirect out of HOLD.

Test Plan:
- Zero-wait memory returning imem_rdata=addr, no stalls -> imem_addr 0,4,8,...; instrD=0x0,0x4,0x8 on consecutive cycles starting 1 cycle after reset; validD=1.
- ready delayed 3 cycles for addr 0x8 -> imem_addr held at 0x8 for 4 cycles; fetch_busy=1 for 3 cycles; IF/ID shows 3 bubbles (validD=0); then instrD=0x8, pcplus4D=0xC.
- stallF=1 and stallD=1 for 2 cycles while word 0x10 returns -> state HOLD, imem_req=0, instrD unchanged; after release instrD=0x10 and next imem_addr=0x14.
- Branch with pcbranchD=0x100, pcsrcD=1 while a fetch of 0x24 is pending (ready 2 cycles later) -> instrD bubble, the 0x24 word is discarded, next imem_addr=0x100, then instrD=word@0x100.
- jumpD=1 and pcsrcD=1 together, instrD[25:0]=0x40, pcplus4D=0x1000_0008 -> next fetch 0x1000_0100, not pcbranchD; pcsrcD=1 with stallD=1 -> no redirect until stallD falls.
- rst asserted mid-request in DROP -> next cycle imem_addr=RESET_PC, validD=0, and the late ready/rdata is ignored.

Source files
------------

// File: rtl/if_stage.sv
// Fetch stage with IF/ID pipeline register for a 5-stage MIPS core.
// Drives a variable-latency request/ready instruction port, applies decode redirects and squashes wrong-path fetches.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        pcsrcD,
    input  logic        jumpD,
    input  logic [31:0] pcbranchD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instrD,
    output logic [31:0] pcplus4D,
    output logic        validD,
    output logic [5:0]  opD,
    output logic [5:0]  functD,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pcplus4_q, hold_pcplus4_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcplus4_q, pcplus4_d;
    logic        valid_q, valid_d;

    logic        redir;
    logic [31:0] redir_target;
    logic [31:0] pc_plus4;
    logic        deliver;
    logic [31:0] deliver_instr;
    logic [31:0] deliver_pcplus4;

    assign redir        = (pcsrcD | jumpD) & ~stallD;
    assign redir_target = jumpD ? {pcplus4_q[31:28], instr_q[25:0], 2'b00} : pcbranchD;
    assign pc_plus4     = pc_q + 32'd4;

    // Request and address come only from registered state, never from hazard inputs.
    assign imem_req   = (state_q != S_HOLD);
    assign imem_addr  = pc_q;
    assign fetch_busy = imem_req & ~imem_ready;

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        hold_instr_d    = hold_instr_q;
        hold_pcplus4_d  = hold_pcplus4_q;
        redir_pc_d      = redir_pc_q;
        deliver         = 1'b0;
        deliver_instr   = imem_rdata;
        deliver_pcplus4 = pc_plus4;

        unique case (state_q)
            S_FETCH: begin
                if (redir) begin
                    if (imem_ready) begin
                        pc_d = redir_target;
                    end else begin
                        redir_pc_d = redir_target;
                        state_d    = S_DROP;
                    end
                end else if (imem_ready) begin
                    if (stallF) begin
                        hold_instr_d   = imem_rdata;
                        hold_pcplus4_d = pc_plus4;
                        state_d        = S_HOLD;
                    end else begin
                        deliver = 1'b1;
                        pc_d    = pc_plus4;
                    end
                end
            end
            S_HOLD: begin
                if (redir) begin
                    pc_d    = redir_target;
                    state_d = S_FETCH;
                end else if (!stallF) begin
                    deliver         = 1'b1;
                    deliver_instr   = hold_instr_q;
                    deliver_pcplus4 = hold_pcplus4_q;
                    pc_d            = hold_pcplus4_q;
                    state_d         = S_FETCH;
                end
            end
            S_DROP: begin
                // The wrong-path word still has to be accepted before the address may move.
                if (redir) begin
                    redir_pc_d = redir_target;
                    if (imem_ready) begin
                        pc_d    = redir_target;
                        state_d = S_FETCH;
                    end
                end else if (imem_ready) begin
                    pc_d    = redir_pc_q;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_comb begin
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        if (stallD) begin
            instr_d   = instr_q;
            pcplus4_d = pcplus4_q;
            valid_d   = valid_q;
        end else if (redir) begin
            instr_d   = 32'd0;
            pcplus4_d = 32'd0;
            valid_d   = 1'b0;
        end else if (deliver) begin
            instr_d   = deliver_instr;
            pcplus4_d = deliver_pcplus4;
            valid_d   = 1'b1;
        end else begin
            instr_d   = 32'd0;
            pcplus4_d = 32'd0;
            valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_FETCH;
            pc_q           <= RESET_PC;
            hold_instr_q   <= 32'd0;
            hold_pcplus4_q <= 32'd0;
            redir_pc_q     <= 32'd0;
            instr_q        <= 32'd0;
            pcplus4_q      <= 32'd0;
            valid_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            hold_instr_q   <= hold_instr_d;
            hold_pcplus4_q <= hold_pcplus4_d;
            redir_pc_q     <= redir_pc_d;
            instr_q        <= instr_d;
            pcplus4_q      <= pcplus4_d;
            valid_q        <= valid_d;
        end
    end

    assign instrD   = instr_q;
    assign pcplus4D = pcplus4_q;
    assign validD   = valid_q;
    assign opD      = instr_q[31:26];
    assign functD   = instr_q[5:0];

endmodule
